// File: rtl/edge_pulse_gen.sv
// edge_pulse_gen
// Multi-channel edge-to-pulse generator. Each channel synchronises its level
// input, detects the selected edge and emits a registered strobe of
// max(len,1) cycles. A sticky miss flag records edges that were dropped.
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - synchronous active-low reset
//   en        - per-channel level inputs (may be asynchronous)
//   mode      - per-channel edge select, bits [2i+1:2i]: 00 off, 01 rise,
//               10 fall, 11 both
//   len       - shared pulse length in cycles (0 behaves as 1)
//   miss_clr  - clears every miss flag
//   pulse_out - registered pulse per channel
//   miss      - sticky per-channel dropped-edge flag
//
// Parameters:
//   N           - number of channels
//   SYNC_STAGES - synchroniser depth (0 = input already synchronous)
//   CNT_W       - width of len and of each channel's down-counter
//   RETRIG      - 1: an edge during a pulse reloads it; 0: it is dropped

module edge_pulse_gen #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int RETRIG      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     en,
  input  logic [2*N-1:0]   mode,
  input  logic [CNT_W-1:0] len,
  input  logic             miss_clr,
  output logic [N-1:0]     pulse_out,
  output logic [N-1:0]     miss
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [N-1:0]     s;
  logic [N-1:0]     prev_q;
  logic [N-1:0]     rise;
  logic [N-1:0]     fall;
  logic [N-1:0]     trig;
  logic [N-1:0]     drop;
  logic [N-1:0]     miss_q;
  logic [N-1:0]     miss_d;
  logic [CNT_W-1:0] load_val;

  state_t           state_q [N];
  state_t           state_d [N];
  logic [CNT_W-1:0] cnt_q   [N];
  logic [CNT_W-1:0] cnt_d   [N];

  // Synchroniser chain; with zero stages the input is used directly.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = en;
    end else begin : g_sync
      logic [N-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= en;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // prev tracks s even for channels whose mode is off, so enabling a
  // channel later does not fire on stale history.
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= s;
  end

  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  always_comb begin
    trig = '0;
    for (int i = 0; i < N; i++) begin
      trig[i] = (mode[2*i] & rise[i]) | (mode[2*i+1] & fall[i]);
    end
  end

  // Counter holds the number of high cycles remaining after the current
  // one, so a load of L-1 gives exactly L high cycles.
  assign load_val = (len == '0) ? '0 : (len - CNT_W'(1));

  // Per-channel next-state, counter and miss logic.
  always_comb begin
    drop   = '0;
    miss_d = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (trig[i]) begin
            state_d[i] = ACTIVE;
            cnt_d[i]   = load_val;
          end
        end
        ACTIVE: begin
          if (trig[i] && (RETRIG != 0)) begin
            cnt_d[i] = load_val;
          end else begin
            drop[i] = trig[i];
            if (cnt_q[i] == '0) state_d[i] = IDLE;
            else                cnt_d[i]   = cnt_q[i] - CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
        end
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      miss_d[i] = drop[i] | (miss_q[i] & ~miss_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      miss_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      miss_q <= miss_d;
    end
  end

  // The pulse is the registered ACTIVE state, so it has no combinational
  // path from the inputs.
  always_comb begin
    pulse_out = '0;
    for (int i = 0; i < N; i++) pulse_out[i] = (state_q[i] == ACTIVE);
  end

  assign miss = miss_q;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// tb_edge_pulse_gen
// Runs two edge_pulse_gen instances (RETRIG=0 and RETRIG=1) on identical
// stimulus and compares both against a cycle-level reference model that
// tracks, per channel, how many high cycles of pulse remain.

module tb_edge_pulse_gen;

  localparam int N     = 4;
  localparam int SYNC  = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     en;
  logic [2*N-1:0]   mode;
  logic [CNT_W-1:0] len;
  logic             miss_clr;
  logic [N-1:0]     pulse_n, miss_n;
  logic [N-1:0]     pulse_r, miss_r;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: en sample history and remaining high cycles.
  // Index 0 models RETRIG=0, index 1 models RETRIG=1.
  logic [N-1:0] hist [SYNC+2];
  int           rem  [2][N];
  logic [N-1:0] miss_m [2];

  int           hi_cnt   [2][N];
  int           rise_cnt [2][N];
  logic [N-1:0] last_p   [2];

  always #5 clk = ~clk;

  edge_pulse_gen #(.N(N), .SYNC_STAGES(SYNC), .CNT_W(CNT_W), .RETRIG(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .len(len),
    .miss_clr(miss_clr), .pulse_out(pulse_n), .miss(miss_n)
  );

  edge_pulse_gen #(.N(N), .SYNC_STAGES(SYNC), .CNT_W(CNT_W), .RETRIG(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .len(len),
    .miss_clr(miss_clr), .pulse_out(pulse_r), .miss(miss_r)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at t=%0t",
               tag, observed, expected, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs now applied.
  task automatic modelEdge();
    logic [N-1:0] sv, pv;
    logic [1:0]   m;
    logic         trig, drop;
    int           l;
    if (!rst_n) begin
      for (int j = 0; j < SYNC + 2; j++) hist[j] = '0;
      for (int k = 0; k < 2; k++) begin
        miss_m[k] = '0;
        for (int i = 0; i < N; i++) rem[k][i] = 0;
      end
    end else begin
      for (int j = SYNC + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = en;
      sv = hist[SYNC];
      pv = hist[SYNC+1];
      l  = (len == 0) ? 1 : int'(len);
      for (int i = 0; i < N; i++) begin
        m    = mode[2*i +: 2];
        trig = (m[0] && sv[i] && !pv[i]) || (m[1] && !sv[i] && pv[i]);
        for (int k = 0; k < 2; k++) begin
          drop = trig && (rem[k][i] > 0) && (k == 0);
          if (trig && (rem[k][i] == 0 || k == 1)) rem[k][i] = l;
          else if (rem[k][i] > 0)                 rem[k][i] = rem[k][i] - 1;
          if (drop)          miss_m[k][i] = 1'b1;
          else if (miss_clr) miss_m[k][i] = 1'b0;
        end
      end
    end
  endtask

  task automatic clearCounts();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        hi_cnt[k][i]   = 0;
        rise_cnt[k][i] = 0;
      end
  endtask

  // Drive one cycle of inputs, step the model at the edge, check just after.
  task automatic applyStimulus(input logic r, input logic [N-1:0] e,
                               input logic [2*N-1:0] m,
                               input logic [CNT_W-1:0] l, input logic c);
    logic [N-1:0] exp_p [2];
    logic [N-1:0] obs_p [2];
    rst_n    = r;
    en       = e;
    mode     = m;
    len      = l;
    miss_clr = c;
    @(posedge clk);
    modelEdge();
    #1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) exp_p[k][i] = (rem[k][i] > 0);
    obs_p[0] = pulse_n;
    obs_p[1] = pulse_r;
    checkOutput("pulse_noretrig", 32'(pulse_n), 32'(exp_p[0]));
    checkOutput("miss_noretrig",  32'(miss_n),  32'(miss_m[0]));
    checkOutput("pulse_retrig",   32'(pulse_r), 32'(exp_p[1]));
    checkOutput("miss_retrig",    32'(miss_r),  32'(miss_m[1]));
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        if (obs_p[k][i]) hi_cnt[k][i]++;
        if (obs_p[k][i] && !last_p[k][i]) rise_cnt[k][i]++;
      end
      last_p[k] = obs_p[k];
    end
  endtask

  task automatic hold(input int cycles, input logic [N-1:0] e,
                      input logic [2*N-1:0] m, input logic [CNT_W-1:0] l);
    for (int c = 0; c < cycles; c++) applyStimulus(1'b1, e, m, l, 1'b0);
  endtask

  initial begin
    logic [N-1:0]     ren;
    logic [2*N-1:0]   rmode;
    logic [CNT_W-1:0] rlen;
    logic             rclr, rrst;

    rst_n = 1'b0; en = '0; mode = '0; len = '0; miss_clr = 1'b0;
    for (int j = 0; j < SYNC + 2; j++) hist[j] = '0;
    last_p[0] = '0;
    last_p[1] = '0;
    clearCounts();

    $display("[TB] reset state");
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, '0, '0, '0, 1'b0);
    checkOutput("reset_pulse", 32'(pulse_n | pulse_r), 32'd0);
    checkOutput("reset_miss",  32'(miss_n | miss_r),   32'd0);

    $display("[TB] basic rise, len=0");
    hold(4, 4'b0000, 8'b00_00_00_01, 8'd0);
    clearCounts();
    hold(2, 4'b0001, 8'b00_00_00_01, 8'd0);
    checkOutput("basic_latency", 32'(pulse_n[0]), 32'd0);
    hold(1, 4'b0001, 8'b00_00_00_01, 8'd0);
    checkOutput("basic_start", 32'(pulse_n[0]), 32'd1);
    hold(10, 4'b0001, 8'b00_00_00_01, 8'd0);
    checkOutput("basic_len_n",   32'(hi_cnt[0][0]),   32'd1);
    checkOutput("basic_len_r",   32'(hi_cnt[1][0]),   32'd1);
    checkOutput("basic_rises_n", 32'(rise_cnt[0][0]), 32'd1);

    $display("[TB] both-edge stretch");
    clearCounts();
    hold(20, 4'b0011, 8'b00_00_11_01, 8'd5);
    hold(12, 4'b0001, 8'b00_00_11_01, 8'd5);
    checkOutput("both_rises_n", 32'(rise_cnt[0][1]), 32'd2);
    checkOutput("both_high_n",  32'(hi_cnt[0][1]),   32'd10);
    checkOutput("both_high_r",  32'(hi_cnt[1][1]),   32'd10);
    checkOutput("both_miss",    32'(miss_n[1]),      32'd0);

    $display("[TB] retrigger vs no retrigger");
    hold(8, 4'b0000, 8'b00_00_11_01, 8'd4);
    clearCounts();
    hold(1, 4'b0001, 8'b00_00_11_01, 8'd4);
    hold(1, 4'b0000, 8'b00_00_11_01, 8'd4);
    hold(10, 4'b0001, 8'b00_00_11_01, 8'd4);
    checkOutput("retrig_high",    32'(hi_cnt[1][0]),   32'd6);
    checkOutput("retrig_rises",   32'(rise_cnt[1][0]), 32'd1);
    checkOutput("noretrig_high",  32'(hi_cnt[0][0]),   32'd4);
    checkOutput("noretrig_rises", 32'(rise_cnt[0][0]), 32'd1);
    checkOutput("noretrig_miss",  32'(miss_n[0]),      32'd1);
    checkOutput("retrig_nomiss",  32'(miss_r[0]),      32'd0);

    $display("[TB] miss clear against simultaneous drop");
    hold(6, 4'b0000, 8'b00_00_11_01, 8'd4);
    hold(1, 4'b0001, 8'b00_00_11_01, 8'd4);
    hold(1, 4'b0000, 8'b00_00_11_01, 8'd4);
    hold(2, 4'b0001, 8'b00_00_11_01, 8'd4);
    applyStimulus(1'b1, 4'b0001, 8'b00_00_11_01, 8'd4, 1'b1);
    checkOutput("miss_set_wins", 32'(miss_n[0]), 32'd1);
    applyStimulus(1'b1, 4'b0001, 8'b00_00_11_01, 8'd4, 1'b1);
    checkOutput("miss_clean_clear", 32'(miss_n[0]), 32'd0);

    $display("[TB] mode off and independence");
    clearCounts();
    for (int t = 0; t < 3; t++) begin
      hold(8, 4'b1101, 8'b10_00_11_01, 8'd3);
      hold(8, 4'b0001, 8'b10_00_11_01, 8'd3);
    end
    checkOutput("off_ch2_n",  32'(rise_cnt[0][2]), 32'd0);
    checkOutput("off_ch2_r",  32'(rise_cnt[1][2]), 32'd0);
    checkOutput("fall_ch3",   32'(rise_cnt[0][3]), 32'd3);
    checkOutput("fall_high3", 32'(hi_cnt[0][3]),   32'd9);

    $display("[TB] reset mid-pulse and reset exit");
    hold(6, 4'b0000, 8'b10_00_11_01, 8'd10);
    hold(5, 4'b0001, 8'b10_00_11_01, 8'd10);
    checkOutput("pre_reset_pulse", 32'(pulse_n[0]), 32'd1);
    applyStimulus(1'b0, 4'b0001, 8'b10_00_11_01, 8'd10, 1'b0);
    checkOutput("reset_mid_n", 32'(pulse_n[0]), 32'd0);
    checkOutput("reset_mid_r", 32'(pulse_r[0]), 32'd0);
    applyStimulus(1'b0, 4'b0001, 8'b10_00_11_01, 8'd10, 1'b0);
    clearCounts();
    hold(20, 4'b0001, 8'b10_00_11_01, 8'd10);
    checkOutput("exit_rises_n", 32'(rise_cnt[0][0]), 32'd1);
    checkOutput("exit_rises_r", 32'(rise_cnt[1][0]), 32'd1);
    checkOutput("exit_high",    32'(hi_cnt[0][0]),   32'd10);

    $display("[TB] maximum length");
    hold(6, 4'b0000, 8'b00_00_00_01, 8'd255);
    clearCounts();
    hold(262, 4'b0001, 8'b00_00_00_01, 8'd255);
    checkOutput("max_len", 32'(hi_cnt[0][0]), 32'd255);

    $display("[TB] randomized stimulus");
    ren = en; rmode = 8'b11_10_01_11; rlen = 8'd3;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5) == 0) ren[i] = ~ren[i];
      if ($urandom_range(49) == 0) rmode = 8'($urandom);
      if ($urandom_range(19) == 0) rlen = 8'($urandom_range(6));
      rclr = ($urandom_range(15) == 0);
      rrst = ($urandom_range(299) != 0);
      applyStimulus(rrst, ren, rmode, rlen, rclr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/edge_pulse_gen.md
Name: edge_pulse_gen

Overview:
- Multi-channel, parametrised edge-to-pulse generator.
- Per channel, it detects a selectable edge (rise, fall or both) on an asynchronous or synchronous level input, then emits a registered pulse of programmable length.
- Supports an optional input synchroniser, a retrigger policy and a sticky missed-event flag.
- Sits between raw control/status levels (buttons, enables, handshake levels) and logic that needs one clean, fixed-width strobe per event.

Parameters:
- N, 4, number of independent channels (≥1).
- SYNC_STAGES, 2, synchroniser flops per channel input (0–3; 0 = input already synchronous, no flops).
- CNT_W, 8, width of the pulse-length field and the per-channel down-counter.
- RETRIG, 0, 1 = an edge during an active pulse reloads the counter; 0 = such an edge is ignored and flagged as missed.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  N  per-channel level inputs.
- mode  input  2N  per-channel edge select, bits [2i+1:2i] for channel i: 00 off, 01 rise, 10 fall, 11 both.
- len  input  CNT_W  pulse length in cycles, shared by all channels; 0 is treated as 1.
- miss_clr  input  1  clears all miss flags.
- pulse_out  output  N  registered pulse per channel.
- miss  output  N  sticky flag, set when an edge was dropped.

Behaviour:
- **Reset:** one clock is synchronous and active-low; reset is sampled on the rising clk edge with rst_n=0. The following all clear to 0: synchroniser flops, the prev register, counters, pulse_out and miss.
- **Reset exit:** because prev resets to 0, an input already high after reset is seen as a rising edge.
- **Synchroniser:** s[i] is en[i] delayed by SYNC_STAGES flops. With SYNC_STAGES=0, s[i] is en[i] combinationally.
- **Edge register:** prev[i] <= s[i] every cycle.
- **Edge detection:**
  - rise = s & ~prev
  - fall = ~s & prev
  - trig = (mode bit0 & rise) | (mode bit1 & fall)
  - mode 00 never triggers, but prev still tracks s.
- **Latency:** pulse_out[i] rises on the clock edge where trig[i] is true. That is SYNC_STAGES+1 edges after en changes, counting the first edge that samples the new level as edge 1.
- **Length:** L = max(len,1), sampled at the trigger edge. pulse_out is high for exactly L cycles. A change to len mid-pulse has no effect on the pulse in flight.
- **Per-channel state machine (2 states):**
  - IDLE: pulse=0. On trig: go to ACTIVE, pulse<=1, cnt<=L-1.
  - ACTIVE, cnt≠0: cnt<=cnt-1.
  - ACTIVE, cnt=0: pulse<=0, go to IDLE.
- **Trigger while ACTIVE (including the final cycle cnt=0):**
  - RETRIG=1: cnt<=L-1 and pulse stays 1. Total high time = cycles already elapsed + L; no gap.
  - RETRIG=0: the edge is dropped and miss[i]<=1. The current pulse ends normally. The next pulse needs a new edge while IDLE.
- **miss:** sticky. Cleared to 0 by miss_clr=1. If miss_clr and a new drop occur in the same cycle, set wins (miss=1).
- **Channel independence:** channels are fully independent. Simultaneous edges on several channels each act per the rules above.
- **Width/overflow:** len=2^CNT_W-1 gives a maximum pulse of 2^CNT_W-1 cycles. The counter never underflows.
- **Reset mid-pulse:** pulse_out drops on the reset edge. Any in-flight pulse is abandoned.

Test Plan:
- **Basic rise, 1 cycle:**
  - Setup: N=4, SYNC_STAGES=2, mode0=01, len=0.
  - Stimulus: en[0] 0→1, held.
  - Required: pulse_out[0]=1 for exactly 1 cycle, starting 3 edges after the change; no further pulse while held.
- **Both-edge stretch:**
  - Setup: mode1=11, len=5.
  - Stimulus: en[1] high for 20 cycles, then low.
  - Required: two 5-cycle pulses, one per edge; miss[1]=0.
- **Retrigger:**
  - Setup: RETRIG=1, len=4.
  - Stimulus: a second rising edge detected on cycle 3 of the pulse.
  - Required: one continuous 6-cycle pulse.
- **No retrigger:**
  - Setup: RETRIG=0, same stimulus as Retrigger.
  - Required: a 4-cycle pulse and miss=1.
  - Stimulus: miss_clr on a cycle with a simultaneous drop.
  - Required: miss stays 1; a clean clear gives 0.
- **Mode off and independence:**
  - Setup: mode2=00, mode3=10.
  - Stimulus: toggle en[2] and en[3] together.
  - Required: no pulse on channel 2; channel 3 pulses only on its falling edges.
- **Reset and reset exit:**
  - Stimulus: assert rst_n=0 during a len=10 pulse.
  - Required: pulse_out=0 on the next edge.
  - Stimulus: release reset with en[0]=1.
  - Required: one pulse is generated for channel 0 (mode01).
